output_port_serializer: RTL and testbench
=========================================

# output_port_serializer

Parametrised successor to the switch's per-port output stage. It arbitrates among `NUM_PORTS` ingress requesters using a round-robin arbiter. It latches the winning `PACKET_WIDTH`-bit packet and serialises it onto a narrower egress bus as `BEATS` beats, MSB slice first, under a valid/ready handshake with framing flags. One instance sits at each egress port of the switch, between the ingress buffers and the egress link.

## Interface
Parameters:
- `NUM_PORTS`, 4: number of ingress requesters; ≥1.
- `PACKET_WIDTH`, 16: packet width in bits; must be divisible by `BEATS`.
- `BEATS`, 2: beats per packet; ≥1.
- `OUT_WIDTH`, `PACKET_WIDTH/BEATS`: derived egress width; not overridable.
- `SEL_WIDTH`, `max(1, $clog2(NUM_PORTS))`: derived.

Ports:
- `clk` in 1: single clock, all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req` in `NUM_PORTS`: per-port request; the packet on `data_in[i]` is valid while `req[i]` is high.
- `data_in` in `NUM_PORTS*PACKET_WIDTH`: flattened packets; port i occupies `[i*PACKET_WIDTH +: PACKET_WIDTH]`.
- `grant` out `NUM_PORTS`: one-hot, one-cycle pop pulse to the port whose packet is latched this cycle.
- `grant_sel` out `SEL_WIDTH`: index of the most recent grant; held between grants.
- `data_out` out `OUT_WIDTH`: current beat.
- `valid_out` out 1: beat valid.
- `ready_in` in 1: downstream accepts the beat when `valid_out && ready_in`.
- `sop` out 1: high with beat 0.
- `eop` out 1: high with beat `BEATS-1`; both flags are high together when `BEATS=1`.

## Operation
- Shared arbitration function used by IDLE and SEND: search from `rr_ptr` upward, wrapping modulo `NUM_PORTS`, and take the first port with `req` set.
- On a grant to port i, in the same cycle:
  - pulse `grant[i]`;
  - load `pkt_reg` from `data_in[i]`;
  - set `grant_sel` to i;
  - set `rr_ptr` to (i+1) mod `NUM_PORTS`;
  - set `beat_cnt` to 0.
- FSM has two states, IDLE and SEND.
- IDLE:
  - `valid_out`=0.
  - If any `req` is set, grant and go to SEND. Otherwise stay in IDLE.
- SEND:
  - Combinational outputs: `valid_out`=1; `data_out` = `pkt_reg[PACKET_WIDTH-1-beat_cnt*OUT_WIDTH -: OUT_WIDTH]`; `sop` = (`beat_cnt`==0); `eop` = (`beat_cnt`==`BEATS-1`).
  - On handshake with `beat_cnt` < `BEATS-1`: increment `beat_cnt`.
  - On handshake with `beat_cnt` == `BEATS-1`:
    - if any `req` is set, grant in the same cycle and stay in SEND with a new packet at beat 0 (no bubble);
    - otherwise go to IDLE.
  - With `ready_in` low: hold `data_out`, `sop`, `eop`, `beat_cnt` and `valid_out`. No grants are issued.
- `req` or `data_in` changing after the grant has no effect on the packet in flight.
- A requester must drop or advance `req` in the cycle after its `grant` pulse. A still-high `req` is treated as a new packet.
- `beat_cnt` has width `max(1,$clog2(BEATS))` and never exceeds `BEATS-1`.
- `rr_ptr` wraps from `NUM_PORTS-1` to 0.

## Timing
- Reset values:
  - state IDLE, `rr_ptr`=0, `pkt_reg`=0, `beat_cnt`=0, `grant_sel`=0;
  - outputs: `grant`=0, `valid_out`=0, `data_out`=0, `sop`=0, `eop`=0.
- `rst` mid-packet: the packet is discarded with no `eop`. Outputs show reset values from the cycle after the `rst` edge.
- Latency: `req` sampled at edge t gives `grant` pulse combinationally in cycle t, and beat 0 is valid in cycle t+1.
- Throughput with `ready_in`=1 and continuous requests: one packet every `BEATS` cycles, `valid_out` continuously high.
- `grant` is combinational from `req`, state and the handshake. Data, flag and `grant_sel` outputs come from registers or register-decoded logic, with no `req`→`data_out` path.

## Structure
- `packet_pkg` holds `PACKET_WIDTH` and `NUM_PORTS` defaults, the `state_t` enum (IDLE, SEND), and `beat_t` / `pkt_t` typedefs.
- Sub-module `rr_arbiter`: inputs `req`, `rr_ptr`, `en`; outputs one-hot `gnt`, `gnt_idx`, `any`. It is purely combinational; `rr_ptr` is owned by the parent.
- The parent holds the FSM, `pkt_reg`, `beat_cnt` and `rr_ptr`.

## Test plan
All scenarios use defaults (4 ports, 16-bit packets, 2 beats) unless noted.
- Reset: hold `rst` for 2 cycles with `req`=4'hF → `grant`, `valid_out`, `data_out`, `sop` and `eop` stay 0. The first grant after release goes to port 0.
- Single packet: `req`=4'b0100, port 2 = 16'hA55A, `ready_in`=1 → `grant`=4'b0100 in cycle t; `data_out`=8'hA5 with `sop` in t+1; 8'h5A with `eop` in t+2; `valid_out`=0 in t+3.
- Fairness: `req`=4'hF held, distinct packets, `ready_in`=1 → grants in order 0,1,2,3,0 every 2 cycles, no `valid_out` gap, `grant_sel` tracks the grants.
- Backpressure: `ready_in`=0 for 3 cycles during beat 0 of 16'hA55A → `data_out`=8'hA5, `sop`=1 and `valid_out`=1 held, no `grant`. Beat 8'h5A follows the cycle after `ready_in` rises.
- Pointer wrap: a grant to port 1, then `req`=4'b1001 → port 3 granted next, then port 0.
- Reset mid-packet: assert `rst` after beat 0 handshakes → `valid_out`=0 the next cycle, no `eop` seen. The next grant with `req`=4'hF goes to port 0.
- Parameter sweep: `NUM_PORTS`=1 with `BEATS`=1, then `NUM_PORTS`=8 with `PACKET_WIDTH`=32, `BEATS`=4 → correct MSB-first slicing and `sop`/`eop` framing.

Source files
------------

// File: rtl/output_port_serializer_pkg.sv
// Shared defaults, FSM state encoding and packet/beat types for the output serializer.
package packet_pkg;

  localparam int PACKET_WIDTH_DEF = 16;
  localparam int NUM_PORTS_DEF    = 4;
  localparam int BEATS_DEF        = 2;

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  typedef logic [PACKET_WIDTH_DEF-1:0]           pkt_t;
  typedef logic [PACKET_WIDTH_DEF/BEATS_DEF-1:0] beat_t;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/output_port_serializer_rr_arbiter.sv
// Combinational round-robin pick: first requester at or above rr_ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int SEL_WIDTH = 2
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [SEL_WIDTH-1:0] rr_ptr,
  input  logic                 en,
  output logic [NUM_PORTS-1:0] gnt,
  output logic [SEL_WIDTH-1:0] gnt_idx,
  output logic                 any
);

  logic [2*NUM_PORTS-1:0] rot;
  int                     pos;

  always_comb begin
    // Doubling the vector turns the wrapping search into a plain scan from bit 0.
    rot     = {req, req} >> rr_ptr;
    any     = 1'b0;
    pos     = 0;
    gnt_idx = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (!any && rot[k]) begin
        any = 1'b1;
        pos = int'(rr_ptr) + k;
        if (pos >= NUM_PORTS) pos = pos - NUM_PORTS;
        gnt_idx = SEL_WIDTH'(pos);
      end
    end
    gnt = (en && any) ? (NUM_PORTS'(1) << gnt_idx) : '0;
  end

endmodule

// File: rtl/output_port_serializer.sv
// Egress stage: round-robin grant of one ingress packet, then MSB-first serialisation
// onto a narrow valid/ready bus with sop/eop framing.
module output_port_serializer
  import packet_pkg::*;
#(
  parameter  int NUM_PORTS    = NUM_PORTS_DEF,
  parameter  int PACKET_WIDTH = PACKET_WIDTH_DEF,
  parameter  int BEATS        = BEATS_DEF,
  localparam int OUT_WIDTH    = PACKET_WIDTH / BEATS,
  localparam int SEL_WIDTH    = clog2_min1(NUM_PORTS)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_PORTS-1:0]              req,
  input  logic [NUM_PORTS*PACKET_WIDTH-1:0] data_in,
  output logic [NUM_PORTS-1:0]              grant,
  output logic [SEL_WIDTH-1:0]              grant_sel,
  output logic [OUT_WIDTH-1:0]              data_out,
  output logic                              valid_out,
  input  logic                              ready_in,
  output logic                              sop,
  output logic                              eop
);

  localparam int                   CNT_W    = clog2_min1(BEATS);
  localparam logic [CNT_W-1:0]     LAST     = CNT_W'(BEATS - 1);
  localparam logic [SEL_WIDTH-1:0] TOP_PORT = SEL_WIDTH'(NUM_PORTS - 1);

  state_t                  state_q, state_d;
  logic [PACKET_WIDTH-1:0] pkt_q, pkt_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [SEL_WIDTH-1:0]    ptr_q, ptr_d;
  logic [SEL_WIDTH-1:0]    sel_q, sel_d;

  logic                 last_hs, arb_en, arb_any;
  logic [SEL_WIDTH-1:0] arb_idx;

  // A new packet may only be taken when idle or as the last beat leaves.
  assign last_hs = (state_q == SEND) && ready_in && (cnt_q == LAST);
  assign arb_en  = !rst && ((state_q == IDLE) || last_hs);

  rr_arbiter #(
    .NUM_PORTS(NUM_PORTS),
    .SEL_WIDTH(SEL_WIDTH)
  ) u_arb (
    .req    (req),
    .rr_ptr (ptr_q),
    .en     (arb_en),
    .gnt    (grant),
    .gnt_idx(arb_idx),
    .any    (arb_any)
  );

  always_comb begin
    state_d = state_q;
    pkt_d   = pkt_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    if (state_q == SEND && ready_in) begin
      if (cnt_q == LAST) state_d = IDLE;
      else               cnt_d   = cnt_q + 1'b1;
    end
    if (arb_en && arb_any) begin
      state_d = SEND;
      pkt_d   = data_in[int'(arb_idx)*PACKET_WIDTH +: PACKET_WIDTH];
      cnt_d   = '0;
      sel_d   = arb_idx;
      ptr_d   = (arb_idx == TOP_PORT) ? '0 : arb_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pkt_q   <= '0;
      cnt_q   <= '0;
      ptr_q   <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      pkt_q   <= pkt_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
    end
  end

  assign grant_sel = sel_q;
  assign valid_out = (state_q == SEND);
  assign sop       = valid_out && (cnt_q == '0);
  assign eop       = valid_out && (cnt_q == LAST);

  always_comb begin
    data_out = '0;
    if (valid_out)
      data_out = OUT_WIDTH'(pkt_q >> ((BEATS - 1 - int'(cnt_q)) * OUT_WIDTH));
  end

endmodule

// File: tb/tb_output_port_serializer.sv
// Three parameterisations driven with directed vectors; a transaction-level model checks every cycle.
module tb_output_port_serializer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ready_in = 1'b1;
  always #5 clk = ~clk;

  // A: 4 ports / 16 bit / 2 beats, B: 1 / 16 / 1, C: 8 / 32 / 4
  logic [3:0]   reqA, grantA;   logic [63:0]  dinA;  logic [1:0] selA; logic [7:0]  doutA; logic vA, sopA, eopA;
  logic [0:0]   reqB, grantB;   logic [15:0]  dinB;  logic [0:0] selB; logic [15:0] doutB; logic vB, sopB, eopB;
  logic [7:0]   reqC, grantC;   logic [255:0] dinC;  logic [2:0] selC; logic [7:0]  doutC; logic vC, sopC, eopC;

  output_port_serializer #(.NUM_PORTS(4), .PACKET_WIDTH(16), .BEATS(2)) dutA (
    .clk(clk), .rst(rst), .req(reqA), .data_in(dinA), .grant(grantA), .grant_sel(selA),
    .data_out(doutA), .valid_out(vA), .ready_in(ready_in), .sop(sopA), .eop(eopA));
  output_port_serializer #(.NUM_PORTS(1), .PACKET_WIDTH(16), .BEATS(1)) dutB (
    .clk(clk), .rst(rst), .req(reqB), .data_in(dinB), .grant(grantB), .grant_sel(selB),
    .data_out(doutB), .valid_out(vB), .ready_in(ready_in), .sop(sopB), .eop(eopB));
  output_port_serializer #(.NUM_PORTS(8), .PACKET_WIDTH(32), .BEATS(4)) dutC (
    .clk(clk), .rst(rst), .req(reqC), .data_in(dinC), .grant(grantC), .grant_sel(selC),
    .data_out(doutC), .valid_out(vC), .ready_in(ready_in), .sop(sopC), .eop(eopC));

  int n_chk = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // ---------------- model: one record per instance ----------------
  int NP[3] = '{4, 1, 8};
  int PW[3] = '{16, 16, 32};
  int BT[3] = '{2, 1, 4};
  bit          m_busy[3];
  int          m_beat[3], m_ptr[3], m_sel[3];
  logic [31:0] m_pkt[3];

  function automatic logic [7:0] rq(input int k);
    case (k)
      0: return {4'b0, reqA};
      1: return {7'b0, reqB};
      default: return reqC;
    endcase
  endfunction

  function automatic logic [255:0] dd(input int k);
    case (k)
      0: return {192'b0, dinA};
      1: return {240'b0, dinB};
      default: return dinC;
    endcase
  endfunction

  // Port the model expects to be granted this cycle, or -1.
  function automatic int pick(input int k);
    logic [7:0] r;
    int p;
    r = rq(k);
    if (rst) return -1;
    if (m_busy[k] && !(ready_in && m_beat[k] == BT[k] - 1)) return -1;
    for (int j = 0; j < NP[k]; j++) begin
      p = (m_ptr[k] + j) % NP[k];
      if (r[p]) return p;
    end
    return -1;
  endfunction

  function automatic logic [63:0] exp_beat(input int k);
    int ow;
    ow = PW[k] / BT[k];
    if (!m_busy[k]) return 64'd0;
    return ({32'b0, m_pkt[k]} >> ((BT[k] - 1 - m_beat[k]) * ow)) & ((64'd1 << ow) - 64'd1);
  endfunction

  initial forever begin
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      automatic int w = pick(k);
      if (rst) begin
        m_busy[k] = 1'b0; m_beat[k] = 0; m_ptr[k] = 0; m_sel[k] = 0; m_pkt[k] = '0;
      end else begin
        if (m_busy[k] && ready_in) begin
          if (m_beat[k] < BT[k] - 1) m_beat[k]++;
          else m_busy[k] = 1'b0;
        end
        if (w >= 0) begin
          m_busy[k] = 1'b1;
          m_beat[k] = 0;
          m_pkt[k]  = 32'((dd(k) >> (w * PW[k])) & ((256'd1 << PW[k]) - 256'd1));
          m_sel[k]  = w;
          m_ptr[k]  = (w + 1) % NP[k];
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      for (int k = 0; k < 3; k++) begin
        automatic int w = pick(k);
        automatic logic [63:0] g, s, d, v, so, eo;
        case (k)
          0: begin g = 64'(grantA); s = 64'(selA); d = 64'(doutA); v = 64'(vA); so = 64'(sopA); eo = 64'(eopA); end
          1: begin g = 64'(grantB); s = 64'(selB); d = 64'(doutB); v = 64'(vB); so = 64'(sopB); eo = 64'(eopB); end
          default: begin g = 64'(grantC); s = 64'(selC); d = 64'(doutC); v = 64'(vC); so = 64'(sopC); eo = 64'(eopC); end
        endcase
        chk($sformatf("dut%0d.grant", k), g, (w >= 0) ? (64'd1 << w) : 64'd0);
        chk($sformatf("dut%0d.grant_sel", k), s, 64'(m_sel[k]));
        chk($sformatf("dut%0d.valid_out", k), v, 64'(m_busy[k]));
        chk($sformatf("dut%0d.sop", k), so, 64'(m_busy[k] && m_beat[k] == 0));
        chk($sformatf("dut%0d.eop", k), eo, 64'(m_busy[k] && m_beat[k] == BT[k] - 1));
        chk($sformatf("dut%0d.data_out", k), d, exp_beat(k));
      end
    end
  end

  // ---------------- directed stimulus with literal expectations ----------------
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic look;
    #3;
  endtask

  initial begin
    reqA = 4'hF; reqB = '0; reqC = '0;
    dinA = {16'h7788, 16'hA55A, 16'h3344, 16'h1122};
    dinB = 16'hBEEF;
    dinC = {32'h1234_5678, 192'b0, 32'hDEAD_BEEF};

    // reset held two cycles with all requests up
    cyc; chk_en = 1'b1; look;
    chk("rst1.grant", 64'(grantA), 0); chk("rst1.valid", 64'(vA), 0);
    chk("rst1.data", 64'(doutA), 0);   chk("rst1.sop", 64'(sopA), 0); chk("rst1.eop", 64'(eopA), 0);
    cyc; look;
    chk("rst2.grant", 64'(grantA), 0); chk("rst2.valid", 64'(vA), 0);
    cyc; rst = 1'b0; look;
    chk("first_grant", 64'(grantA), 64'b0001);

    // fairness: grants 0,1,2,3,0 every two cycles
    cyc; look; chk("fair.beat0", 64'(doutA), 64'h11); chk("fair.sop", 64'(sopA), 1);
    cyc; look; chk("fair.g1", 64'(grantA), 64'b0010); chk("fair.beat1", 64'(doutA), 64'h22);
    chk("fair.eop", 64'(eopA), 1);
    cyc; look; chk("fair.sel1", 64'(selA), 1); chk("fair.p1b0", 64'(doutA), 64'h33);
    cyc; look; chk("fair.g2", 64'(grantA), 64'b0100);
    cyc; cyc; look; chk("fair.g3", 64'(grantA), 64'b1000);
    cyc; cyc; look; chk("fair.g0", 64'(grantA), 64'b0001);
    cyc; reqA = 4'h0;
    cyc; cyc; look; chk("fair.idle", 64'(vA), 0);

    // single packet from port 2
    cyc; reqA = 4'b0100; look; chk("single.grant", 64'(grantA), 64'b0100);
    cyc; reqA = 4'h0; look;
    chk("single.b0", 64'(doutA), 64'hA5); chk("single.sop", 64'(sopA), 1); chk("single.v", 64'(vA), 1);
    cyc; look; chk("single.b1", 64'(doutA), 64'h5A); chk("single.eop", 64'(eopA), 1);
    cyc; look; chk("single.idle", 64'(vA), 0);

    // backpressure on beat 0
    cyc; reqA = 4'b0100; look; chk("bp.grant", 64'(grantA), 64'b0100);
    cyc; reqA = 4'b0001; ready_in = 1'b0; look;
    chk("bp.hold_data", 64'(doutA), 64'hA5); chk("bp.hold_sop", 64'(sopA), 1);
    chk("bp.hold_v", 64'(vA), 1); chk("bp.no_grant", 64'(grantA), 0);
    cyc; look; chk("bp.hold2", 64'(doutA), 64'hA5); chk("bp.no_grant2", 64'(grantA), 0);
    cyc; look; chk("bp.hold3", 64'(doutA), 64'hA5); chk("bp.no_grant3", 64'(grantA), 0);
    cyc; ready_in = 1'b1; reqA = 4'h0; look; chk("bp.release", 64'(doutA), 64'hA5);
    cyc; look; chk("bp.b1", 64'(doutA), 64'h5A); chk("bp.eop", 64'(eopA), 1);
    cyc; look; chk("bp.idle", 64'(vA), 0);

    // pointer wrap: port 1, then 3, then 0
    cyc; reqA = 4'b0010; look; chk("wrap.g1", 64'(grantA), 64'b0010);
    cyc; reqA = 4'h0;
    cyc; reqA = 4'b1001; look; chk("wrap.g3", 64'(grantA), 64'b1000);
    cyc; reqA = 4'b0001; look; chk("wrap.p3b0", 64'(doutA), 64'h77); chk("wrap.no_grant", 64'(grantA), 0);
    cyc; look; chk("wrap.g0", 64'(grantA), 64'b0001);
    cyc; reqA = 4'h0;
    cyc; cyc; look; chk("wrap.idle", 64'(vA), 0);

    // reset mid-packet
    cyc; reqA = 4'b0100; look; chk("rmid.grant", 64'(grantA), 64'b0100);
    cyc; reqA = 4'h0; rst = 1'b1; look; chk("rmid.b0", 64'(doutA), 64'hA5);
    cyc; rst = 1'b0; reqA = 4'hF; look;
    chk("rmid.v", 64'(vA), 0); chk("rmid.no_eop", 64'(eopA), 0); chk("rmid.grant0", 64'(grantA), 64'b0001);
    cyc; reqA = 4'h0; look; chk("rmid.p0b0", 64'(doutA), 64'h11);
    cyc; cyc; look; chk("rmid.idle", 64'(vA), 0);

    // single port, single beat: back-to-back packets
    cyc; reqB = 1'b1; look; chk("b.grant", 64'(grantB), 1);
    cyc; dinB = 16'hCAFE; look;
    chk("b.beat", 64'(doutB), 64'hBEEF); chk("b.sop", 64'(sopB), 1); chk("b.eop", 64'(eopB), 1);
    chk("b.regrant", 64'(grantB), 1);
    cyc; reqB = 1'b0; look; chk("b.beat2", 64'(doutB), 64'hCAFE);
    cyc; look; chk("b.idle", 64'(vB), 0);

    // eight ports, four beats
    cyc; reqC = 8'h80; look; chk("c.grant7", 64'(grantC), 64'h80);
    cyc; reqC = 8'h00; look; chk("c.b0", 64'(doutC), 64'h12); chk("c.sop", 64'(sopC), 1);
    cyc; look; chk("c.b1", 64'(doutC), 64'h34); chk("c.mid_flags", 64'({sopC, eopC}), 0);
    cyc; look; chk("c.b2", 64'(doutC), 64'h56);
    cyc; reqC = 8'h81; look;
    chk("c.b3", 64'(doutC), 64'h78); chk("c.eop", 64'(eopC), 1); chk("c.grant0", 64'(grantC), 64'h01);
    cyc; reqC = 8'h00; look;
    chk("c.p0b0", 64'(doutC), 64'hDE); chk("c.sel0", 64'(selC), 0);
    cyc; cyc; cyc; look; chk("c.p0b3", 64'(doutC), 64'hEF);
    cyc; look; chk("c.idle", 64'(vC), 0);

    cyc; chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
